// File: rtl/infer_pkg.sv
// Shared types and defaults for the inference controller.
// Holds the FSM state enum, the data word type and the flush/window defaults.
package infer_pkg;

  typedef logic signed [31:0] word_t;

  localparam int FLUSH_LEN_DEF  = 2;
  localparam int STREAM_LEN_DEF = 256;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    RUN,
    CAPTURE,
    SAMPLE,
    RESULT
  } infer_state_t;

endpackage

// File: rtl/inference_controller_argmax.sv
// argmax: combinational index of the largest signed element; ties -> lowest index.
// Ports: data (OUTPUT_SIZE words in), idx ($clog2(OUTPUT_SIZE) bits out).
module argmax
  import infer_pkg::*;
#(
  parameter int OUTPUT_SIZE = 3
) (
  input  word_t                          data [0:OUTPUT_SIZE-1],
  output logic [$clog2(OUTPUT_SIZE)-1:0] idx
);

  localparam int KW = $clog2(OUTPUT_SIZE);

  word_t best;

  // Strict '>' keeps the earlier index on equal values.
  always_comb begin
    best = data[0];
    idx  = '0;
    for (int i = 1; i < OUTPUT_SIZE; i++) begin
      if (data[i] > best) begin
        best = data[i];
        idx  = KW'(i);
      end
    end
  end

endmodule

// File: rtl/inference_controller.sv
// inference_controller: sequences one bitstream inference per input vector:
// latch input, flush network (net_clr_n low), run STREAM_LEN cycles, pulse
// compute, sample net_output, hold result until out_ready.
// Ports: clk, n_rst (async, active-low); in_valid/in_ready/in_data input
// handshake; abort cancels an inference; net_input/net_clr_n/compute drive
// the network; net_output returns results; out_valid/out_ready/out_data/
// out_class result handshake; busy high outside IDLE.
// Optional: define INFERENCE_ARGMAX_EN to compute out_class (else tied 0).
module inference_controller
  import infer_pkg::*;
#(
  parameter int INPUT_SIZE  = 4,
  parameter int OUTPUT_SIZE = 3,
  parameter int STREAM_LEN  = STREAM_LEN_DEF,
  parameter int FLUSH_LEN   = FLUSH_LEN_DEF
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  word_t                          in_data [0:INPUT_SIZE-1],
  input  logic                           abort,
  output word_t                          net_input [0:INPUT_SIZE-1],
  output logic                           net_clr_n,
  output logic                           compute,
  input  word_t                          net_output [0:OUTPUT_SIZE-1],
  output logic                           out_valid,
  input  logic                           out_ready,
  output word_t                          out_data [0:OUTPUT_SIZE-1],
  output logic [$clog2(OUTPUT_SIZE)-1:0] out_class,
  output logic                           busy
);

  localparam int CW = $clog2(STREAM_LEN + 1);
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam int KW = $clog2(OUTPUT_SIZE);

  infer_state_t  state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fcnt;

`ifdef INFERENCE_ARGMAX_EN
  logic [KW-1:0] cls_q;
  logic [KW-1:0] cls_nxt;

  argmax #(
    .OUTPUT_SIZE(OUTPUT_SIZE)
  ) u_argmax (
    .data(net_output),
    .idx (cls_nxt)
  );

  assign out_class = cls_q;
`else
  assign out_class = '0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      net_clr_n <= 1'b0;
      compute   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      fcnt      <= '0;
      for (int i = 0; i < INPUT_SIZE; i++)
        net_input[i] <= '0;
      for (int i = 0; i < OUTPUT_SIZE; i++)
        out_data[i] <= '0;
`ifdef INFERENCE_ARGMAX_EN
      cls_q <= '0;
`endif
    end else begin
      compute <= 1'b0;
      unique case (state)
        IDLE: begin
          net_clr_n <= 1'b1;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          if (in_valid && in_ready) begin
            net_input <= in_data;
            state     <= FLUSH;
            in_ready  <= 1'b0;
            net_clr_n <= 1'b0;
            busy      <= 1'b1;
            fcnt      <= '0;
          end
        end
        FLUSH: begin
          if (abort) begin
            state     <= IDLE;
            net_clr_n <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end else if (fcnt == FW'(FLUSH_LEN - 1)) begin
            state     <= RUN;
            net_clr_n <= 1'b1;
            cnt       <= '0;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            net_clr_n <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end else if (cnt == CW'(STREAM_LEN - 1)) begin
            state   <= CAPTURE;
            compute <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (abort) begin
            state     <= IDLE;
            net_clr_n <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state     <= IDLE;
            net_clr_n <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            out_data  <= net_output;
            out_valid <= 1'b1;
            state     <= RESULT;
`ifdef INFERENCE_ARGMAX_EN
            cls_q <= cls_nxt;
`endif
          end
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inference_controller.sv
// tb_inference_controller: scoreboard bench for inference_controller.
// Expected results queued at issue time; a negedge monitor pops and compares.
module tb_inference_controller;
  import infer_pkg::*;

`ifdef INFERENCE_ARGMAX_EN
  localparam bit AMX = 1'b1;
`else
  localparam bit AMX = 1'b0;
`endif

  localparam int COMP_LAT = 258;
  localparam int OUT_LAT  = 260;

  typedef struct {
    int d0;
    int d1;
    int d2;
    int cls;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       in_valid;
  logic       in_ready;
  word_t      in_data [0:3];
  logic       abort;
  word_t      net_input [0:3];
  logic       net_clr_n;
  logic       compute;
  word_t      net_output [0:2];
  logic       out_valid;
  logic       out_ready;
  word_t      out_data [0:2];
  logic [1:0] out_class;
  logic       busy;

  inference_controller dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .net_input (net_input),
    .net_clr_n (net_clr_n),
    .compute   (compute),
    .net_output(net_output),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_class (out_class),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  int   exp_in [0:3];
  int   cyc = 0;
  int   hs_cyc = 0;
  int   hs_count = 0;
  int   comp_count = 0;
  int   ov_count = 0;
  int   exp_done = 0;
  bit   ov_prev = 1'b0;
  bit   cp_prev = 1'b0;
  int   hold_d [0:2];
  int   hold_c;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  // Input handshake monitor
  always @(posedge clk) begin
    cyc++;
    if (n_rst && in_valid && in_ready) begin
      hs_count++;
      hs_cyc = cyc;
      chk("hs_in_idle_busy", int'(busy), 0);
    end
  end

  // Output / compute monitor
  always @(negedge clk) begin
    if (!n_rst) begin
      ov_prev = 1'b0;
      cp_prev = 1'b0;
    end else begin
      if (compute) begin
        chk("compute_width", int'(cp_prev), 0);
        if (!cp_prev) begin
          comp_count++;
          chk("compute_lat", cyc - hs_cyc, COMP_LAT);
          for (int i = 0; i < 4; i++)
            chk("net_input_hold", int'(net_input[i]), exp_in[i]);
        end
      end
      if (out_valid && !ov_prev) begin
        ov_count++;
        chk("out_lat", cyc - hs_cyc, OUT_LAT);
        chk("in_ready_low_res", int'(in_ready), 0);
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data0", int'(out_data[0]), e.d0);
          chk("out_data1", int'(out_data[1]), e.d1);
          chk("out_data2", int'(out_data[2]), e.d2);
          chk("out_class", int'(out_class), e.cls);
        end
        for (int i = 0; i < 3; i++)
          hold_d[i] = int'(out_data[i]);
        hold_c = int'(out_class);
      end else if (out_valid) begin
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_class", int'(out_class), hold_c);
        for (int i = 0; i < 3; i++)
          chk("bp_data", int'(out_data[i]), hold_d[i]);
      end
      ov_prev = out_valid;
      cp_prev = compute;
    end
  end

  task automatic set_in(input int a, input int b, input int c, input int d);
    in_data[0] = a; in_data[1] = b;
    in_data[2] = c; in_data[3] = d;
    exp_in[0] = a; exp_in[1] = b;
    exp_in[2] = c; exp_in[3] = d;
  endtask

  task automatic set_net(input int a, input int b, input int c);
    net_output[0] = a;
    net_output[1] = b;
    net_output[2] = c;
  endtask

  task automatic push(input int a, input int b, input int c, input int cls);
    exp_t e;
    e.d0 = a; e.d1 = b; e.d2 = c;
    e.cls = AMX ? cls : 0;
    sb.push_back(e);
    exp_done++;
  endtask

  // Offer in_valid until the monitor records a handshake.
  task automatic offer();
    int base;
    bit got;
    base = hs_count;
    got = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (hs_count > base) got = 1'b1;
    end
    in_valid = 1'b0;
    if (!got) chk("hs_timeout", 0, 1);
  endtask

  // Wait for out_valid, stall dly cycles, then accept.
  task automatic take(input int dly);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("out_timeout", 0, 1);
    end else begin
      repeat (dly) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_out_valid", int'(out_valid), 0);
      chk("idle_in_ready", int'(in_ready), 1);
      chk("idle_busy", int'(busy), 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_clr_n"}, int'(net_clr_n), 0);
    chk({tag, "_compute"}, int'(compute), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_class"}, int'(out_class), 0);
    for (int i = 0; i < 4; i++)
      chk({tag, "_net_input"}, int'(net_input[i]), 0);
    for (int i = 0; i < 3; i++)
      chk({tag, "_out_data"}, int'(out_data[i]), 0);
  endtask

  initial begin
    int base;
    int cbase;
    int obase;
    n_rst = 1'b1;
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    set_in(0, 0, 0, 0);
    set_net(0, 0, 0);
    #2 n_rst = 1'b0;
    #1 chk_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    #3 n_rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(in_ready), 1);
    chk("rel_clr_n", int'(net_clr_n), 1);

    // Nominal
    set_in(10, 200, 50, 0);
    set_net(-5, 40, 700);
    push(-5, 40, 700, 2);
    offer();
    take(0);

    // Argmax tie
    set_in(1, 2, 3, 4);
    set_net(90, 120, 120);
    push(90, 120, 120, 1);
    offer();
    take(0);

    // Backpressure
    set_in(7, 7, 7, 7);
    set_net(500, -100, 499);
    push(500, -100, 499, 0);
    offer();
    take(20);

    // Abort at RUN count 100
    cbase = comp_count;
    obase = ov_count;
    set_in(3, 1, 4, 1);
    set_net(11, 22, 33);
    offer();
    repeat (102) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_clr_n", int'(net_clr_n), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    chk("abort_clr_n_after", int'(net_clr_n), 1);
    repeat (300) @(negedge clk);
    chk("abort_no_compute", comp_count, cbase);
    chk("abort_no_out", ov_count, obase);

    // Async reset mid-RUN
    set_in(9, 8, 7, 6);
    offer();
    repeat (50) @(negedge clk);
    #3 n_rst = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    #3 n_rst = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", int'(in_ready), 1);
    set_in(5, 6, 7, 8);
    set_net(-7, -3, -9);
    push(-7, -3, -9, 1);
    offer();
    take(0);

    // in_valid held over two inferences
    base = hs_count;
    set_in(100, 0, 100, 0);
    set_net(1, 2, 3);
    push(1, 2, 3, 2);
    push(1, 2, 3, 2);
    @(negedge clk);
    in_valid = 1'b1;
    take(0);
    @(negedge clk);
    in_valid = 1'b0;
    take(0);
    repeat (10) @(negedge clk);
    chk("two_handshakes", hs_count - base, 2);

    chk("sb_empty", sb.size(), 0);
    chk("total_compute", comp_count, exp_done);
    chk("total_out", ov_count, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inference_controller.md
INFERENCE_CONTROLLER -- requirements
Module: inference_controller

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 4, the number of network input values.
REQ-002 SHALL have parameter OUTPUT_SIZE, default 3, the number of network output values.
REQ-003 SHALL have parameter STREAM_LEN, default 256, the number of bitstream cycles integrated per inference.
REQ-004 SHALL have parameter FLUSH_LEN, default 2, the number of cycles the network clear is held low before the run window.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock for the block.
- n_rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  an input vector is offered.
- in_ready  out  1  the controller accepts an input vector.
- in_data  in  int[0:INPUT_SIZE-1]  input vector.
- abort  in  1  synchronous cancel of the current inference.
- net_input  out  int[0:INPUT_SIZE-1]  registered vector driving the network inputs.
- net_clr_n  out  1  active-low clear to the network and its generators/integrators.
- compute  out  1  capture strobe to the network integrators.
- net_output  in  int[0:OUTPUT_SIZE-1]  integrator results.
- out_valid  out  1  a result is held.
- out_ready  in  1  the consumer accepts the result.
- out_data  out  int[0:OUTPUT_SIZE-1]  registered result vector.
- out_class  out  $clog2(OUTPUT_SIZE)  index of the largest result.
- busy  out  1  high in every state except IDLE.

Function
REQ-006 SHALL implement the FSM states IDLE, FLUSH, RUN, CAPTURE, SAMPLE and RESULT.
REQ-007 SHALL drive in_ready high only in IDLE; an input handshake (in_valid & in_ready) SHALL latch in_data into net_input and move the FSM to FLUSH.
REQ-008 SHALL hold net_clr_n low for exactly FLUSH_LEN cycles in FLUSH, then move to RUN with net_clr_n high.
REQ-009 SHALL count exactly STREAM_LEN cycles in RUN, using a counter of width $clog2(STREAM_LEN+1) that is cleared on entry to RUN, then move to CAPTURE.
REQ-010 SHALL assert compute for exactly one cycle, in CAPTURE.
REQ-011 SHALL, in SAMPLE (the cycle after CAPTURE), register net_output into out_data, load out_class, and move to RESULT.
REQ-012 SHALL hold out_valid high in RESULT, with out_data and out_class held stable, until out_ready is high; on that handshake the FSM SHALL return to IDLE on the next edge.
REQ-013 SHALL accept the earliest next input no sooner than the cycle after the output handshake, because in_ready is low while in RESULT.
REQ-014 SHALL treat abort high in FLUSH, RUN, CAPTURE or SAMPLE as follows: next state IDLE, net_clr_n low for that one transition cycle, and no out_valid for that inference.
REQ-015 SHALL ignore abort in RESULT, so a held result is never dropped, and SHALL ignore abort in IDLE.
REQ-016 SHALL keep net_input constant from FLUSH through SAMPLE.
REQ-017 SHALL set the end-to-end latency from the input handshake to out_valid to FLUSH_LEN+STREAM_LEN+2 cycles.

Reset
REQ-018 SHALL, on n_rst low, asynchronously set: state IDLE, net_clr_n 0, compute 0, out_valid 0, busy 0, counters 0, net_input all 0, out_data all 0, out_class 0.
REQ-019 SHALL drive in_ready 1 on the first edge after n_rst releases, and net_clr_n 1 while in IDLE.
REQ-020 SHALL, when reset is asserted mid-inference, discard that inference with no spurious compute pulse.

Configuration
REQ-021 SHALL use the macro INFERENCE_ARGMAX_EN to compile the argmax in or out.
- Defined: out_class is the index of the maximum out_data element, computed as signed int; ties go to the lowest index.
- Undefined: out_class is tied to 0 and no comparator logic is present.

Structure
REQ-022 SHALL place the FSM state enum infer_state_t and the flush/window defaults in the shared package infer_pkg.
REQ-023 SHALL place the argmax in one combinational sub-module, argmax, parameterised by OUTPUT_SIZE, instantiated only under INFERENCE_ARGMAX_EN.

Verification
REQ-024 SHALL cover these directed scenarios:
- Nominal: input {10,200,50,0} accepted, STREAM_LEN=256. Required: compute pulse exactly 258 cycles after the handshake, out_valid at cycle 260.
- Argmax tie: net_output {90,120,120} at SAMPLE. Required: out_class=1 with argmax enabled; out_class=0 with INFERENCE_ARGMAX_EN undefined.
- Backpressure: out_ready low for 20 cycles. Required: out_valid, out_data and out_class stable and in_ready low throughout; back to IDLE one cycle after out_ready rises.
- Abort at RUN count 100. Required: IDLE next cycle, net_clr_n low for one cycle, no compute pulse, no out_valid.
- Asynchronous reset mid-RUN. Required: all outputs take their reset values immediately, with no clock edge needed; a new inference after release completes normally.
- in_valid held continuously over two inferences. Required: exactly two handshakes, each occurring only in IDLE.
